// File: rtl/pwmin_pkg.sv
// pwmin_pkg: shared FSM state encoding and counter width for the PWM scanner
package pwmin_pkg;
  localparam int CNT_W = 32;
  typedef enum logic [2:0] {SETTLE, WAIT_RISE, HIGH, LOW, NEXT} state_t;
endpackage

// File: rtl/pwmin_sync.sv
// pwmin_sync: two-flop synchronizer for one asynchronous input bit
module pwmin_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] s_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= 2'b00;
    else s_q <= {s_q[0], d_i};
  end
  assign q_o = s_q[1];
endmodule

// File: rtl/pwmin_scan.sv
// pwmin_scan: round-robin PWM width/period measurement sharing one counter and edge
// detector across all channels, with a registered-read result bank
module pwmin_scan
  import pwmin_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int TIMEOUT  = 25000000,
  parameter int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pwm_i,
  input  logic [CH_BITS-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]    rd_width_o,
  output logic [CNT_W-1:0]    rd_period_o,
  output logic                rd_valid_o,
  output logic [CH_BITS-1:0]  cur_ch_o,
  output logic                scan_done_o
);
  localparam logic [CNT_W-1:0]   TO   = CNT_W'(TIMEOUT);
  localparam logic [CH_BITS-1:0] LAST = CH_BITS'(CHANNELS - 1);
  logic [CHANNELS-1:0] pwm_s, bank_v_q;
  logic [CNT_W-1:0]    bank_w_q [CHANNELS];
  logic [CNT_W-1:0]    bank_p_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_q, cnt_d, width_tmp_q, rd_width_q, rd_period_q;
  logic [CH_BITS-1:0]  cur_ch_q;
  logic [1:0]          h_q;
  logic                rd_valid_q, scan_done_q, rise, fall, timed_out, rd_ok;
  state_t              state_q;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_sync
    pwmin_sync u_sync (.clk(clk), .rst(rst), .d_i(pwm_i[i]), .q_o(pwm_s[i]));
  end
  always_comb begin
    rise      = h_q == 2'b01;
    fall      = h_q == 2'b10;
    timed_out = cnt_q > TO;
    cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    rd_ok     = 32'(rd_sel_i) < CHANNELS;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SETTLE;
      cnt_q       <= '0;
      width_tmp_q <= '0;
      h_q         <= '0;
      cur_ch_q    <= '0;
      scan_done_q <= 1'b0;
      rd_width_q  <= '0;
      rd_period_q <= '0;
      rd_valid_q  <= 1'b0;
      bank_v_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        bank_w_q[i] <= '0;
        bank_p_q[i] <= '0;
      end
    end else begin
      h_q         <= {h_q[0], pwm_s[cur_ch_q]};
      scan_done_q <= 1'b0;
      // reads sample the bank before this cycle's write lands
      rd_width_q  <= rd_ok ? bank_w_q[rd_sel_i] : '0;
      rd_period_q <= rd_ok ? bank_p_q[rd_sel_i] : '0;
      rd_valid_q  <= rd_ok & bank_v_q[rd_sel_i];
      case (state_q)
        SETTLE: begin
          cnt_q   <= cnt_q[0] ? '0 : cnt_q + CNT_W'(1);
          state_q <= cnt_q[0] ? WAIT_RISE : SETTLE;
        end
        WAIT_RISE, HIGH, LOW:
          if (timed_out) begin
            bank_w_q[cur_ch_q] <= h_q[0] ? TO : '0;
            bank_p_q[cur_ch_q] <= TO;
            bank_v_q[cur_ch_q] <= 1'b0;
            state_q            <= NEXT;
          end else if (state_q == WAIT_RISE && rise) begin
            cnt_q   <= CNT_W'(1);
            state_q <= HIGH;
          end else if (state_q == LOW && rise) begin
            bank_w_q[cur_ch_q] <= width_tmp_q;
            bank_p_q[cur_ch_q] <= cnt_q;
            bank_v_q[cur_ch_q] <= 1'b1;
            state_q            <= NEXT;
          end else begin
            cnt_q <= cnt_d;
            if (state_q == HIGH && fall) begin
              width_tmp_q <= cnt_q;
              state_q     <= LOW;
            end
          end
        NEXT: begin
          cur_ch_q    <= (cur_ch_q == LAST) ? '0 : cur_ch_q + CH_BITS'(1);
          scan_done_q <= cur_ch_q == LAST;
          cnt_q       <= '0;
          state_q     <= SETTLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= SETTLE;
        end
      endcase
    end
  end
  assign rd_width_o  = rd_width_q;
  assign rd_period_o = rd_period_q;
  assign rd_valid_o  = rd_valid_q;
  assign cur_ch_o    = cur_ch_q;
  assign scan_done_o = scan_done_q;
endmodule

// File: tb/tb_pwmin_scan.sv
// tb_pwmin_scan: directed bench for pwmin_scan with TIMEOUT=1000, plus a 3-channel
// instance for the out-of-range read address
module tb_pwmin_scan;
  localparam int TO = 1000;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] pwm = '0;
  logic [1:0] rd_sel = '0, cur_ch;
  logic [31:0] rd_width, rd_period;
  logic rd_valid, scan_done;
  logic [2:0] pwm3 = '0;
  logic [1:0] rd_sel3 = 2'd3, cur_ch3;
  logic [31:0] rd_width3, rd_period3;
  logic rd_valid3, scan_done3;
  int hi_c[4], lo_c[4], ph[4];
  int errors = 0, checks = 0;
  pwmin_scan #(.CHANNELS(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pwm_i(pwm), .rd_sel_i(rd_sel),
    .rd_width_o(rd_width), .rd_period_o(rd_period), .rd_valid_o(rd_valid),
    .cur_ch_o(cur_ch), .scan_done_o(scan_done)
  );
  pwmin_scan #(.CHANNELS(3), .TIMEOUT(TO)) dut3 (
    .clk(clk), .rst(rst), .pwm_i(pwm3), .rd_sel_i(rd_sel3),
    .rd_width_o(rd_width3), .rd_period_o(rd_period3), .rd_valid_o(rd_valid3),
    .cur_ch_o(cur_ch3), .scan_done_o(scan_done3)
  );
  always #5 clk = ~clk;
  // pwm generator: hi cycles high then lo cycles low; lo==0 means constant high
  initial begin
    for (int c = 0; c < 4; c++) begin
      hi_c[c] = 0;
      lo_c[c] = 1;
      ph[c]   = 0;
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        pwm[c] = (lo_c[c] == 0) ? 1'b1 : (ph[c] < hi_c[c]);
        ph[c]  = (ph[c] + 1 >= hi_c[c] + lo_c[c]) ? 0 : ph[c] + 1;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask
  task automatic chk_ent(input string tag, input int ch, input int w, input int p, input int v);
    rd_sel = 2'(ch);
    @(negedge clk);
    chk({tag, "_w"}, rd_width, w);
    chk({tag, "_p"}, rd_period, p);
    chk({tag, "_v"}, 32'(rd_valid), v);
  endtask
  task automatic wait_sd(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_done !== 1'b1 && n < budget);
    chk(tag, 32'(scan_done), 1);
  endtask
  task automatic wait_ch(input string tag, input int ch, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(cur_ch) != ch && n < budget);
    chk(tag, 32'(cur_ch), ch);
  endtask
  initial begin
    int seq[$];
    int n;
    logic [31:0] pw, pp;
    repeat (3) @(negedge clk);
    chk("rst_w", rd_width, 0);
    chk("rst_p", rd_period, 0);
    chk("rst_v", 32'(rd_valid), 0);
    chk("rst_ch", 32'(cur_ch), 0);
    chk("rst_sd", 32'(scan_done), 0);
    chk("rst3_ch", 32'(cur_ch3), 0);
    chk("rst3_sd", 32'(scan_done3), 0);
    hi_c[0] = 30; lo_c[0] = 70;
    hi_c[2] = 1;  lo_c[2] = 0;
    rst = 1'b0;
    // round 1: ch0 30/100, ch1 idle low, ch2 stuck high, ch3 stuck low
    wait_sd("sd1", 6000);
    rd_sel = 2'd0;
    @(negedge clk);
    chk_rng("r1_ch0_w", rd_width, 29, 31);
    chk_rng("r1_ch0_p", rd_period, 99, 101);
    chk("r1_ch0_v", 32'(rd_valid), 1);
    chk_ent("r1_ch1", 1, 0, TO, 0);
    chk_ent("r1_ch2", 2, TO, TO, 0);
    chk_ent("r1_ch3", 3, 0, TO, 0);
    wait_ch("r2_ch1", 1, 500);
    chk_ent("r2_ch0", 0, 30, 100, 1);
    hi_c[0] = 10; lo_c[0] = 40;
    hi_c[1] = 20; lo_c[1] = 30;
    hi_c[2] = 25; lo_c[2] = 75;
    hi_c[3] = 1;  lo_c[3] = 2;
    wait_sd("sd2", 6000);
    // round 3: rd_sel held on the channel being stored
    rd_sel = 2'd0;
    seq.push_back(int'(cur_ch));
    pw = rd_width;
    pp = rd_period;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (int'(cur_ch) != seq[$]) begin
        seq.push_back(int'(cur_ch));
        if (seq.size() == 2) begin
          chk("coll_old_w", pw, 30);
          chk("coll_old_p", pp, 100);
          chk("coll_new_w", rd_width, 10);
          chk("coll_new_p", rd_period, 50);
        end
      end
      pw = rd_width;
      pp = rd_period;
    end while (scan_done !== 1'b1 && n < 4000);
    chk("sd3", 32'(scan_done), 1);
    chk("seq_len", seq.size(), 5);
    for (int i = 0; i < 5 && i < seq.size(); i++) chk($sformatf("seq%0d", i), seq[i], i % 4);
    hi_c[1] = 0; lo_c[1] = 1;
    chk_ent("r3_ch0", 0, 10, 50, 1);
    chk_ent("r3_ch1", 1, 20, 50, 1);
    chk_ent("r3_ch2", 2, 25, 100, 1);
    chk_ent("r3_ch3", 3, 1, 3, 1);
    @(negedge clk);
    chk("c3_oor_w", rd_width3, 0);
    chk("c3_oor_p", rd_period3, 0);
    chk("c3_oor_v", 32'(rd_valid3), 0);
    rd_sel3 = 2'd0;
    @(negedge clk);
    chk("c3_ch0_p", rd_period3, TO);
    chk("c3_ch0_v", 32'(rd_valid3), 0);
    // abort mid-HIGH on ch1
    rd_sel = 2'd0;
    wait_ch("r4_ch1", 1, 500);
    repeat (4) @(negedge clk);
    hi_c[1] = 1; lo_c[1] = 0;
    repeat (10) @(negedge clk);
    chk("pre_rst_w", rd_width, 10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_w", rd_width, 0);
    chk("arst_p", rd_period, 0);
    chk("arst_v", 32'(rd_valid), 0);
    chk("arst_ch", 32'(cur_ch), 0);
    chk("arst_sd", 32'(scan_done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_ent("post_rst0", 0, 0, 0, 0);
    chk_ent("post_rst2", 2, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
